// File: rtl/mpc_cnstr_pkg.sv
// Shared types and default sizing for the constraint RAM arbiter and its RAM.
package mpc_cnstr_pkg;

  localparam int DefDataWidth    = 32;
  localparam int DefAddressWidth = 3;
  localparam int DefAddressRange = 8;
  localparam int NumReq          = 2;

  typedef enum logic {
    INIT = 1'b0,
    ARB  = 1'b1
  } arb_state_e;

  typedef logic req_id_t;

  localparam req_id_t ReqId0 = 1'b0;
  localparam req_id_t ReqId1 = 1'b1;

  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mpc_cnstr_ram_1r1w.sv
// Single-port read-first RAM with chip enable and a one-cycle registered read port.
module mpc_cnstr_ram_1r1w #(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 3,
  parameter int Depth        = 8
) (
  input  logic                    clk,
  input  logic                    ce,
  input  logic                    we,
  input  logic [AddressWidth-1:0] addr,
  input  logic [DataWidth-1:0]    d,
  output logic [DataWidth-1:0]    q
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rd_q;

  // Read-first: q carries the old word even on a write cycle.
  always_ff @(posedge clk) begin
    if (ce) begin
      rd_q <= mem_q[addr];
      if (we) begin
        mem_q[addr] <= d;
      end
    end
  end

  assign q = rd_q;

endmodule

// File: rtl/mpc_constraint_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a zero-cleared constraint RAM.
// Defining MPC_CNSTR_ARB_STATS_EN adds a saturating conflict_cnt output.
module mpc_constraint_ram_arbiter
  import mpc_cnstr_pkg::*;
#(
  parameter int DataWidth    = DefDataWidth,
  parameter int AddressWidth = DefAddressWidth,
  parameter int AddressRange = DefAddressRange
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    init_done,
  input  logic                    r0_valid,
  output logic                    r0_ready,
  input  logic                    r0_we,
  input  logic [AddressWidth-1:0] r0_addr,
  input  logic [DataWidth-1:0]    r0_wdata,
  output logic                    r0_rvalid,
  output logic [DataWidth-1:0]    r0_rdata,
  input  logic                    r1_valid,
  output logic                    r1_ready,
  input  logic                    r1_we,
  input  logic [AddressWidth-1:0] r1_addr,
  input  logic [DataWidth-1:0]    r1_wdata,
  output logic                    r1_rvalid,
  output logic [DataWidth-1:0]    r1_rdata
`ifdef MPC_CNSTR_ARB_STATS_EN
 ,output logic [15:0]             conflict_cnt
`endif
);

  localparam int                    LastAddrInt = AddressRange - 1;
  localparam logic [AddressWidth-1:0] LastAddr  = LastAddrInt[AddressWidth-1:0];
  localparam logic [AddressWidth:0]   RangeLimit = AddressRange[AddressWidth:0];

  arb_state_e state_q, state_d;
  logic [AddressWidth-1:0] sweep_q, sweep_d;
  logic init_done_q, init_done_d;
  req_id_t last_q, last_d;
  logic oor_q, oor_d;
  logic [NumReq-1:0] rvalid_q, rvalid_d;
  logic [NumReq-1:0][DataWidth-1:0] rdata_hold_q, rdata_hold_d;

  logic [NumReq-1:0] req_valid, req_we, req_ready;
  logic [NumReq-1:0][AddressWidth-1:0] req_addr;
  logic [NumReq-1:0][DataWidth-1:0] req_wdata;
  logic [NumReq-1:0][DataWidth-1:0] rdata_out;

  req_id_t grant_id;
  logic xfer, in_range;
  logic [AddressWidth-1:0] sel_addr;
  logic [DataWidth-1:0] sel_wdata;
  logic sel_we;

  logic ram_ce, ram_we;
  logic [AddressWidth-1:0] ram_addr;
  logic [DataWidth-1:0] ram_d, ram_q, rd_word;

  assign req_valid = {r1_valid, r0_valid};
  assign req_we    = {r1_we, r0_we};
  assign req_addr  = {r1_addr, r0_addr};
  assign req_wdata = {r1_wdata, r0_wdata};

  // On a conflict the requester that did not win last time gets the slot.
  always_comb begin
    req_ready = '0;
    if (state_q == ARB) begin
      if (&req_valid) begin
        req_ready[other_req(last_q)] = 1'b1;
      end else begin
        req_ready = req_valid;
      end
    end
  end

  assign grant_id  = req_ready[1] ? ReqId1 : ReqId0;
  assign xfer      = |req_ready;
  assign sel_addr  = req_addr[grant_id];
  assign sel_wdata = req_wdata[grant_id];
  assign sel_we    = req_we[grant_id];
  assign in_range  = {1'b0, sel_addr} < RangeLimit;

  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = sweep_q;
    ram_d    = '0;
    if (state_q == INIT) begin
      ram_ce = 1'b1;
      ram_we = 1'b1;
    end else begin
      ram_ce   = xfer && in_range;
      ram_we   = sel_we;
      ram_addr = sel_addr;
      ram_d    = sel_wdata;
    end
  end

  mpc_cnstr_ram_1r1w #(
    .DataWidth   (DataWidth),
    .AddressWidth(AddressWidth),
    .Depth       (AddressRange)
  ) u_ram (
    .clk (clk),
    .ce  (ram_ce),
    .we  (ram_we),
    .addr(ram_addr),
    .d   (ram_d),
    .q   (ram_q)
  );

  // Out-of-range reads never touch the RAM and return zero.
  assign rd_word = oor_q ? '0 : ram_q;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    assign rvalid_d[gi]     = (state_q == ARB) && req_ready[gi] && !req_we[gi];
    assign rdata_out[gi]    = rvalid_q[gi] ? rd_word : rdata_hold_q[gi];
    assign rdata_hold_d[gi] = rdata_out[gi];
  end

  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    init_done_d = init_done_q;
    last_d      = last_q;
    oor_d       = !in_range;
    case (state_q)
      INIT: begin
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LastAddr) begin
          state_d     = ARB;
          init_done_d = 1'b1;
          sweep_d     = '0;
        end
      end
      ARB: begin
        if (xfer) begin
          last_d = grant_id;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      init_done_q  <= 1'b0;
      last_q       <= ReqId1;
      oor_q        <= 1'b0;
      rvalid_q     <= '0;
      rdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      init_done_q  <= init_done_d;
      last_q       <= last_d;
      oor_q        <= oor_d;
      rvalid_q     <= rvalid_d;
      rdata_hold_q <= rdata_hold_d;
    end
  end

  assign init_done = init_done_q;
  assign r0_ready  = req_ready[0];
  assign r1_ready  = req_ready[1];
  assign r0_rvalid = rvalid_q[0];
  assign r1_rvalid = rvalid_q[1];
  assign r0_rdata  = rdata_out[0];
  assign r1_rdata  = rdata_out[1];

`ifdef MPC_CNSTR_ARB_STATS_EN
  logic [15:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if ((state_q == ARB) && (&req_valid) && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      conflict_cnt_q <= '0;
    end else begin
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mpc_constraint_ram_arbiter.sv
// Directed bench for mpc_constraint_ram_arbiter; define MPC_CNSTR_ARB_STATS_EN to cover conflict_cnt.
module tb_mpc_constraint_ram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        init_done;
  logic        r0_valid, r0_ready, r0_we, r0_rvalid;
  logic [2:0]  r0_addr;
  logic [31:0] r0_wdata, r0_rdata;
  logic        r1_valid, r1_ready, r1_we, r1_rvalid;
  logic [2:0]  r1_addr;
  logic [31:0] r1_wdata, r1_rdata;
`ifdef MPC_CNSTR_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  int passed = 0;
  int total  = 0;

  mpc_constraint_ram_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .init_done(init_done),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_we    (r0_we),
    .r0_addr  (r0_addr),
    .r0_wdata (r0_wdata),
    .r0_rvalid(r0_rvalid),
    .r0_rdata (r0_rdata),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_we    (r1_we),
    .r1_addr  (r1_addr),
    .r1_wdata (r1_wdata),
    .r1_rvalid(r1_rvalid),
    .r1_rdata (r1_rdata)
`ifdef MPC_CNSTR_ARB_STATS_EN
   ,.conflict_cnt(conflict_cnt)
`endif
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = 3'd0; r0_wdata = 32'h0;
    r1_valid = 1'b0; r1_we = 1'b0; r1_addr = 3'd0; r1_wdata = 32'h0;
  endtask

  task automatic set_req(input logic req, input logic we, input logic [2:0] addr,
                         input logic [31:0] data);
    if (req) begin
      r1_valid = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = data;
    end else begin
      r0_valid = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = data;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from release until init_done, bounded so a stuck sweep still ends.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 20) begin
      tick();
      n++;
    end
    chk32(tag, n, 32'd8);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    idle();
    r0_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_init_done", init_done, 1'b0);
    chk1("rst_r0_ready", r0_ready, 1'b0);
    chk1("rst_r1_ready", r1_ready, 1'b0);
    chk1("rst_r0_rvalid", r0_rvalid, 1'b0);
    chk1("rst_r1_rvalid", r1_rvalid, 1'b0);
    chk32("rst_r0_rdata", r0_rdata, 32'h0);
    chk32("rst_r1_rdata", r1_rdata, 32'h0);

    reset = 1'b1;
    #1;
    chk1("init_ready_low", r0_ready, 1'b0);
    idle();
    wait_init("init_cycles");

    for (int a = 0; a < 8; a++) begin
      idle();
      set_req(1'b0, 1'b0, a[2:0], 32'h0);
      #1;
      chk1("sweep_rd_ready", r0_ready, 1'b1);
      tick();
      chk1("sweep_rd_rvalid", r0_rvalid, 1'b1);
      chk32("sweep_rd_data", r0_rdata, 32'h0);
      chk1("sweep_rd_r1_quiet", r1_rvalid, 1'b0);
    end

    idle();
    set_req(1'b0, 1'b1, 3'd3, 32'hDEADBEEF);
    #1;
    chk1("wr3_ready", r0_ready, 1'b1);
    tick();
    chk1("wr3_no_rvalid", r0_rvalid, 1'b0);
    idle();
    set_req(1'b0, 1'b0, 3'd3, 32'h0);
    #1;
    chk1("rd3_ready", r0_ready, 1'b1);
    tick();
    chk1("rd3_rvalid", r0_rvalid, 1'b1);
    chk32("rd3_data", r0_rdata, 32'hDEADBEEF);

    idle();
    set_req(1'b1, 1'b1, 3'd2, 32'h00000055);
    #1;
    chk1("wr2_r1_ready", r1_ready, 1'b1);
    chk1("wr2_r0_not_ready", r0_ready, 1'b0);
    tick();
    chk1("wr2_r0_rvalid_low", r0_rvalid, 1'b0);
    chk1("wr2_r1_rvalid_low", r1_rvalid, 1'b0);
    chk32("hold_r0_rdata", r0_rdata, 32'hDEADBEEF);

    idle();
    set_req(1'b0, 1'b0, 3'd3, 32'h0);
    set_req(1'b1, 1'b0, 3'd2, 32'h0);
    for (int i = 0; i < 6; i++) begin
      logic g0;
      g0 = ((i % 2) == 0);
      #1;
      chk1("rr_r0_ready", r0_ready, g0);
      chk1("rr_r1_ready", r1_ready, !g0);
      tick();
      chk1("rr_r0_rvalid", r0_rvalid, g0);
      chk1("rr_r1_rvalid", r1_rvalid, !g0);
      if (g0) chk32("rr_r0_rdata", r0_rdata, 32'hDEADBEEF);
      else    chk32("rr_r1_rdata", r1_rdata, 32'h00000055);
    end

    idle();
    set_req(1'b1, 1'b1, 3'd5, 32'h00001234);
    #1;
    chk1("wr5_r1_ready", r1_ready, 1'b1);
    chk1("wr5_r0_idle", r0_ready, 1'b0);
    tick();
    chk1("wr5_no_rvalid", r1_rvalid, 1'b0);
    idle();
    set_req(1'b1, 1'b0, 3'd5, 32'h0);
    #1;
    chk1("rd5_r1_ready", r1_ready, 1'b1);
    tick();
    chk1("rd5_rvalid", r1_rvalid, 1'b1);
    chk32("rd5_data", r1_rdata, 32'h00001234);
    chk1("rd5_r0_quiet", r0_rvalid, 1'b0);
    idle();
    tick();
    chk1("rd5_rvalid_pulse", r1_rvalid, 1'b0);
    chk32("rd5_hold", r1_rdata, 32'h00001234);

    reset = 1'b0;
    #1;
    chk1("rst2_init_done", init_done, 1'b0);
    tick();
    reset = 1'b1;
    repeat (4) tick();
    chk1("mid_init_not_done", init_done, 1'b0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    wait_init("init_after_init_pulse");

    tick();
    set_req(1'b0, 1'b0, 3'd3, 32'h0);
    #1;
    chk1("arb_pulse_ready", r0_ready, 1'b1);
    tick();
    chk1("arb_pulse_rvalid_pre", r0_rvalid, 1'b1);
    reset = 1'b0;
    #1;
    chk1("arb_pulse_rvalid_drop", r0_rvalid, 1'b0);
    chk32("arb_pulse_rdata_zero", r0_rdata, 32'h0);
    chk1("arb_pulse_ready_low", r0_ready, 1'b0);
    chk1("arb_pulse_init_done", init_done, 1'b0);
    tick();
    chk1("arb_pulse_rvalid_held", r0_rvalid, 1'b0);
    reset = 1'b1;
    #1;
    chk1("arb_pulse_init_ready", r0_ready, 1'b0);
    idle();
    wait_init("init_after_arb_pulse");

    set_req(1'b0, 1'b0, 3'd3, 32'h0);
    set_req(1'b1, 1'b0, 3'd5, 32'h0);
    for (int i = 0; i < 10; i++) begin
      logic g0;
      g0 = ((i % 2) == 0);
      #1;
      chk1("rr2_r0_ready", r0_ready, g0);
      chk1("rr2_r1_ready", r1_ready, !g0);
      tick();
      chk1("rr2_r0_rvalid", r0_rvalid, g0);
      chk1("rr2_r1_rvalid", r1_rvalid, !g0);
      if (g0) chk32("rr2_r0_cleared", r0_rdata, 32'h0);
      else    chk32("rr2_r1_cleared", r1_rdata, 32'h0);
    end
    idle();

`ifdef MPC_CNSTR_ARB_STATS_EN
    chk32("conflict_cnt_10", 32'(conflict_cnt), 32'd10);
    tick();
    chk32("conflict_cnt_idle", 32'(conflict_cnt), 32'd10);
    force dut.conflict_cnt_q = 16'hFFFD;
    #1;
    release dut.conflict_cnt_q;
    set_req(1'b0, 1'b0, 3'd1, 32'h0);
    set_req(1'b1, 1'b0, 3'd1, 32'h0);
    tick();
    chk32("conflict_cnt_fffe", 32'(conflict_cnt), 32'h0000FFFE);
    tick();
    chk32("conflict_cnt_ffff", 32'(conflict_cnt), 32'h0000FFFF);
    tick();
    chk32("conflict_cnt_sat", 32'(conflict_cnt), 32'h0000FFFF);
    idle();
`endif

    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
